mem_arbiter: RTL

- Shares one memory port between two requesters: port 0 is the CPU control path; port 1 is the loader/debug path.
- Each requester issues mem_ctrl_op_e operations (MEM_NOP/MEM_READ/MEM_WRITE) and holds them until its done pulse.
- The arbiter grants round-robin, latches the transaction, forwards it to memory, returns read data, and aborts on timeout.
- Sits between the requesters and the memory controller; its done pulses replace the raw mem_op_done the requesters would otherwise see.

---
 rtl/controlpack.sv | 30 +++
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/arb_timeout.sv | 43 ++++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/controlpack.sv
// controlpack: shared control-path types.
//   mem_ctrl_op_e : memory operation encoding used by requesters and memory
//   arb_state_e   : mem_arbiter FSM states
//   arb_port_e    : mem_arbiter requester port identifiers
//   is_request()  : true only for legal, non-NOP operations
package controlpack;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } mem_ctrl_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUSY    = 2'b01,
        ST_RELEASE = 2'b10
    } arb_state_e;

    typedef enum logic {
        ARB_P0 = 1'b0,
        ARB_P1 = 1'b1
    } arb_port_e;

    // The unused encoding 2'b11 is deliberately not a request.
    function automatic logic is_request(input logic [1:0] op);
        return (op == MEM_READ) || (op == MEM_WRITE);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between two requesters, the arbiter and memory.
//   req0_* / req1_* : requester op/addr/wdata in, rdata/done out
//   mem_*           : memory op/addr/wdata out, rdata/done in
//   grant, err      : owning port and timeout pulse
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters + memory)
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);

    logic [1:0]            req0_op;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic [DATA_WIDTH-1:0] req0_rdata;
    logic                  req0_done;

    logic [1:0]            req1_op;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic [DATA_WIDTH-1:0] req1_rdata;
    logic                  req1_done;

    logic [1:0]            mem_op;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_done;

    logic                  grant;
    logic                  err;

    modport slave (
        input  req0_op, req0_addr, req0_wdata,
        output req0_rdata, req0_done,
        input  req1_op, req1_addr, req1_wdata,
        output req1_rdata, req1_done,
        output mem_op, mem_addr, mem_wdata,
        input  mem_rdata, mem_done,
        output grant, err
    );

    modport master (
        output req0_op, req0_addr, req0_wdata,
        input  req0_rdata, req0_done,
        output req1_op, req1_addr, req1_wdata,
        input  req1_rdata, req1_done,
        input  mem_op, mem_addr, mem_wdata,
        output mem_rdata, mem_done,
        input  grant, err
    );

endinterface

// File: rtl/arb_timeout.sv
// arb_timeout: loadable up-counter with clear and enable, flagging expiry.
//   clock, reset   : clock, asynchronous active-low reset
//   i_clear        : force count to zero (highest priority)
//   i_load         : load i_load_value
//   i_load_value   : value loaded when i_load is high
//   i_enable       : increment count
//   o_expired      : count equals TIMEOUT_CYCLES-1 (never when TIMEOUT_CYCLES=0)
module arb_timeout #(
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_value,
    input  logic          i_enable,
    output logic          o_expired
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign o_expired = 1'b0;
        end else begin : g_enabled
            assign o_expired = (r_count == CW'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory port between two requesters
// (port 0 = CPU control path, port 1 = loader/debug path).
//   clock, reset : clock, asynchronous active-low reset
//   bus          : mem_arbiter_if.slave carrying
//                  req0/req1 op/addr/wdata in, rdata/done out,
//                  mem op/addr/wdata out, mem rdata/done in,
//                  grant (owning port, valid in BUSY), err (timeout pulse)
// A granted transaction is latched and forwarded; completion (or timeout)
// pulses the owner's done for the single RELEASE cycle.
module mem_arbiter
    import controlpack::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    arb_state_e            r_state;
    arb_port_e             r_rr;
    arb_port_e             r_grant;
    mem_ctrl_op_e          r_mem_op;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic                  r_done0;
    logic                  r_done1;
    logic                  r_err;

    logic                  w_req0;
    logic                  w_req1;
    arb_port_e             w_pick;
    logic                  w_start;
    logic [1:0]            w_pick_op;
    logic [ADDR_WIDTH-1:0] w_pick_addr;
    logic [DATA_WIDTH-1:0] w_pick_wdata;
    logic                  w_tmo_enable;
    logic                  w_expired;

    assign w_req0 = is_request(bus.req0_op);
    assign w_req1 = is_request(bus.req1_op);

    // Contention goes to the round-robin pointer; otherwise to whoever asks.
    assign w_pick = (w_req0 && w_req1) ? r_rr :
                    (w_req1 ? ARB_P1 : ARB_P0);

    assign w_start      = (r_state == ST_IDLE) && (w_req0 || w_req1);
    assign w_pick_op    = (w_pick == ARB_P1) ? bus.req1_op    : bus.req0_op;
    assign w_pick_addr  = (w_pick == ARB_P1) ? bus.req1_addr  : bus.req0_addr;
    assign w_pick_wdata = (w_pick == ARB_P1) ? bus.req1_wdata : bus.req0_wdata;

    // Counts only BUSY cycles without completion; cleared on every grant.
    assign w_tmo_enable = (r_state == ST_BUSY) && !bus.mem_done;

    arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock        (clock),
        .reset        (reset),
        .i_clear      (w_start),
        .i_load       (1'b0),
        .i_load_value ({CW{1'b0}}),
        .i_enable     (w_tmo_enable),
        .o_expired    (w_expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_rr        <= ARB_P0;
            r_grant     <= ARB_P0;
            r_mem_op    <= MEM_NOP;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_mem_op    <= mem_ctrl_op_e'(w_pick_op);
                        r_mem_addr  <= w_pick_addr;
                        r_mem_wdata <= w_pick_wdata;
                        r_grant     <= w_pick;
                        r_rr        <= (w_pick == ARB_P0) ? ARB_P1 : ARB_P0;
                        r_state     <= ST_BUSY;
                    end else begin
                        r_mem_op    <= MEM_NOP;
                    end
                end

                ST_BUSY: begin
                    // Completion wins over a timeout landing in the same cycle.
                    if (bus.mem_done) begin
                        r_mem_op <= MEM_NOP;
                        if (r_grant == ARB_P1) begin
                            r_done1 <= 1'b1;
                            if (r_mem_op == MEM_READ) begin
                                r_rdata1 <= bus.mem_rdata;
                            end
                        end else begin
                            r_done0 <= 1'b1;
                            if (r_mem_op == MEM_READ) begin
                                r_rdata0 <= bus.mem_rdata;
                            end
                        end
                        r_state <= ST_RELEASE;
                    end else if (w_expired) begin
                        r_mem_op <= MEM_NOP;
                        r_err    <= 1'b1;
                        if (r_grant == ARB_P1) begin
                            r_done1 <= 1'b1;
                        end else begin
                            r_done0 <= 1'b1;
                        end
                        r_state <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    // Requests seen here predate the done pulse, so skip them.
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_mem_op <= MEM_NOP;
                    r_done0  <= 1'b0;
                    r_done1  <= 1'b0;
                    r_err    <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_op     = r_mem_op;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.req0_rdata = r_rdata0;
    assign bus.req1_rdata = r_rdata1;
    assign bus.req0_done  = r_done0;
    assign bus.req1_done  = r_done1;
    assign bus.grant      = r_grant;
    assign bus.err        = r_err;

endmodule
